systolic_result_writer: RTL and testbench

- Write-side counterpart to the systolic-array row address generator: drains result tiles from the array and stores them into a single-port result RAM.
- Accepts one tile per handshake. A tile is SYSTOLIC_WIDTH lane values, one per result row of the current row group, all in the same column.
- Serialises each tile into one RAM write per valid lane, generating row-major addresses for an M1_WIDTH x M2_WIDTH result matrix.
- Signals completion once the whole matrix has been written.

---
 rtl/systolic_result_writer.sv | 139 +++++++++++++
 tb/tb_systolic_result_writer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_result_writer
//  Description : Drains result tiles (one lane per result row, same column)
//                from a systolic array and writes them one element per cycle
//                into a single-port result RAM in row-major order. Lanes that
//                fall past the last matrix row are padding and are skipped.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_result_writer #(
    parameter int SYSTOLIC_WIDTH = 2,
    parameter int M1_WIDTH       = 3,
    parameter int M2_WIDTH       = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 start_in,
    input  logic                                 tile_valid_in,
    output logic                                 tile_ready_out,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] tile_data_in,
    output logic                                 wr_en_out,
    output logic [ADDR_WIDTH-1:0]                wr_addr_out,
    output logic [DATA_WIDTH-1:0]                wr_data_out,
    output logic                                 busy_out,
    output logic                                 done_out
);

    // Counter widths: row group and column must hold their full range
    // without wrap; the lane index only ever spans 0..SYSTOLIC_WIDTH-1.
    localparam int RG_W   = $clog2(M1_WIDTH + 1);
    localparam int COL_W  = $clog2(M2_WIDTH + 1);
    localparam int LANE_W = (SYSTOLIC_WIDTH > 1) ? $clog2(SYSTOLIC_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [RG_W-1:0]                      row_group_q, row_group_d;
    logic [COL_W-1:0]                     col_q, col_d;
    logic [LANE_W-1:0]                    lane_q, lane_d;
    logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] tile_q, tile_d;

    logic [DATA_WIDTH-1:0]                lane_val [SYSTOLIC_WIDTH];
    logic                                 last_lane;

    // Split the captured tile into addressable lane values.
    for (genvar g = 0; g < SYSTOLIC_WIDTH; g++) begin : g_lane
        assign lane_val[g] = tile_q[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // A lane is the last of its tile at the group edge or at the last matrix row.
    assign last_lane = (lane_q == LANE_W'(SYSTOLIC_WIDTH - 1)) ||
                       ((32'(row_group_q) + 32'(lane_q)) == 32'(M1_WIDTH - 1));

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            row_group_q <= '0;
            col_q       <= '0;
            lane_q      <= '0;
            tile_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_group_q <= row_group_d;
            col_q       <= col_d;
            lane_q      <= lane_d;
            tile_q      <= tile_d;
        end
    end

    // Next-state logic: arm, accept a tile, walk its lanes, advance col/group.
    always_comb begin
        state_d     = state_q;
        row_group_d = row_group_q;
        col_d       = col_q;
        lane_d      = lane_q;
        tile_d      = tile_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d     = S_WAIT;
                    row_group_d = '0;
                    col_d       = '0;
                end
            end
            S_WAIT: begin
                if (tile_valid_in) begin
                    tile_d  = tile_data_in;
                    lane_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!last_lane) begin
                    lane_d = lane_q + 1'b1;
                end else if (col_q != COL_W'(M2_WIDTH - 1)) begin
                    col_d   = col_q + 1'b1;
                    state_d = S_WAIT;
                end else if ((32'(row_group_q) + 32'(SYSTOLIC_WIDTH)) < 32'(M1_WIDTH)) begin
                    col_d       = '0;
                    row_group_d = RG_W'(32'(row_group_q) + 32'(SYSTOLIC_WIDTH));
                    state_d     = S_WAIT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only; address/data zero when idle.
    always_comb begin
        tile_ready_out = (state_q == S_WAIT);
        wr_en_out      = (state_q == S_WRITE);
        busy_out       = (state_q != S_IDLE);
        done_out       = (state_q == S_DONE);
        wr_addr_out    = '0;
        wr_data_out    = '0;
        if (state_q == S_WRITE) begin
            wr_addr_out = ADDR_WIDTH'((32'(row_group_q) + 32'(lane_q)) * 32'(M2_WIDTH)
                                      + 32'(col_q));
            wr_data_out = lane_val[lane_q];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_result_writer
//  Description : Directed self-checking bench for systolic_result_writer,
//                default 2x(3x2) instance plus a 4-lane 4x1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_result_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, tvalid, tready;
    logic [15:0] tdata;
    logic        wr_en, busy, done;
    logic [7:0]  wr_addr, wr_data;

    logic        start4, tvalid4, tready4;
    logic [31:0] tdata4;
    logic        wr_en4, busy4, done4;
    logic [7:0]  wr_addr4, wr_data4;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] log_addr [$];
    logic [7:0] log_data [$];
    int         log_cyc  [$];
    int         done_cnt, done_cyc, ready_cnt;

    logic [7:0] c_addr [6] = '{8'd0, 8'd2, 8'd1, 8'd3, 8'd4, 8'd5};
    logic [7:0] c_data [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    always #5 clk = ~clk;

    systolic_result_writer u_dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .start_in       (start),
        .tile_valid_in  (tvalid),
        .tile_ready_out (tready),
        .tile_data_in   (tdata),
        .wr_en_out      (wr_en),
        .wr_addr_out    (wr_addr),
        .wr_data_out    (wr_data),
        .busy_out       (busy),
        .done_out       (done)
    );

    systolic_result_writer #(
        .SYSTOLIC_WIDTH (4),
        .M1_WIDTH       (4),
        .M2_WIDTH       (1),
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (8)
    ) u_dut4 (
        .clk_in         (clk),
        .rst_in         (rst),
        .start_in       (start4),
        .tile_valid_in  (tvalid4),
        .tile_ready_out (tready4),
        .tile_data_in   (tdata4),
        .wr_en_out      (wr_en4),
        .wr_addr_out    (wr_addr4),
        .wr_data_out    (wr_data4),
        .busy_out       (busy4),
        .done_out       (done4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // RAM-side monitor: records every write and done pulse mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            log_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (tready) ready_cnt = ready_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cnt  = 0;
        done_cyc  = 0;
        ready_cnt = 0;
    endtask

    task automatic send_tile(input logic [15:0] d, input bit keep);
        int n = 0;
        tvalid = 1'b1;
        tdata  = d;
        while (!tready && n < 20) begin
            step();
            n++;
        end
        if (!tready) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: tile_ready_out=%0b required 1", tready);
        end
        step();
        if (!keep) tvalid = 1'b0;
    endtask

    task automatic wait_done;
        int n = 0;
        while (done_cnt == 0 && n < 30) begin
            step();
            n++;
        end
        if (done_cnt == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: done_out never pulsed");
        end
    endtask

    task automatic start_xfer;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; tvalid = 1'b0; tdata = '0;
        start4 = 1'b0; tvalid4 = 1'b0; tdata4 = '0;
        step();
        n_cmp++;
        if ({tready, wr_en, wr_addr, wr_data, busy, done, tready4, wr_en4, busy4, done4} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%0b wr_en=%0b addr=%0h data=%0h busy=%0b done=%0b required all 0",
                     tready, wr_en, wr_addr, wr_data, busy, done);
        end
        step();
        rst = 1'b0;
        n_cmp++;
        if ({tready, wr_en, wr_addr, wr_data, busy, done} !== '0) begin
            n_err++;
            $display("FAIL post_reset_outputs: ready=%0b wr_en=%0b addr=%0h data=%0h busy=%0b done=%0b required all 0",
                     tready, wr_en, wr_addr, wr_data, busy, done);
        end
    endtask

    task automatic test_basic;
        clear_log();
        start_xfer();
        n_cmp++;
        if ({busy, tready} !== 2'b11) begin
            n_err++;
            $display("FAIL wait_state: busy=%0b ready=%0b required 1 1", busy, tready);
        end
        send_tile(16'h2211, 1'b0);
        send_tile(16'h4433, 1'b0);
        send_tile(16'hEE55, 1'b0);
        send_tile(16'hFF66, 1'b0);
        wait_done();
        step(); step();
        n_cmp++;
        if (log_addr.size() !== 6) begin
            n_err++;
            $display("FAIL basic_write_count: %0d required 6", log_addr.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (i >= log_addr.size()) begin
                n_err++;
                $display("FAIL basic_write[%0d]: missing required (%0d,%0h)", i, c_addr[i], c_data[i]);
            end else if (log_addr[i] !== c_addr[i] || log_data[i] !== c_data[i]) begin
                n_err++;
                $display("FAIL basic_write[%0d]: (%0d,%0h) required (%0d,%0h)",
                         i, log_addr[i], log_data[i], c_addr[i], c_data[i]);
            end
        end
        n_cmp++;
        if (log_cyc.size() == 6 && (done_cyc !== log_cyc[5] + 1 || done_cnt !== 1)) begin
            n_err++;
            $display("FAIL basic_done: cycle=%0d count=%0d required cycle=%0d count=1",
                     done_cyc, done_cnt, log_cyc[5] + 1);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle_busy: %0b required 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int rel [6] = '{0, 1, 3, 4, 6, 8};
        clear_log();
        start_xfer();
        send_tile(16'h2211, 1'b1);
        send_tile(16'h4433, 1'b1);
        send_tile(16'hEE55, 1'b1);
        send_tile(16'hFF66, 1'b1);
        tvalid = 1'b0;
        wait_done();
        n_cmp++;
        if (ready_cnt !== 4) begin
            n_err++;
            $display("FAIL b2b_ready_cycles: %0d required 4", ready_cnt);
        end
        n_cmp++;
        if (log_cyc.size() !== 6) begin
            n_err++;
            $display("FAIL b2b_write_count: %0d required 6", log_cyc.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                n_cmp++;
                if (log_cyc[i] - log_cyc[0] !== rel[i] || log_addr[i] !== c_addr[i]) begin
                    n_err++;
                    $display("FAIL b2b_timing[%0d]: offset=%0d addr=%0d required offset=%0d addr=%0d",
                             i, log_cyc[i] - log_cyc[0], log_addr[i], rel[i], c_addr[i]);
                end
            end
            n_cmp++;
            if (done_cyc - log_cyc[0] !== 9) begin
                n_err++;
                $display("FAIL b2b_done_offset: %0d required 9", done_cyc - log_cyc[0]);
            end
        end
    endtask

    task automatic test_ignore_valid;
        clear_log();
        tvalid = 1'b1;
        tdata  = 16'hBEEF;
        step(); step(); step();
        tvalid = 1'b0;
        n_cmp++;
        if (log_addr.size() !== 0 || busy !== 1'b0 || ready_cnt !== 0) begin
            n_err++;
            $display("FAIL idle_valid: writes=%0d busy=%0b ready_cycles=%0d required 0 0 0",
                     log_addr.size(), busy, ready_cnt);
        end
        start_xfer();
        send_tile(16'h2211, 1'b0);
        tvalid = 1'b1;
        tdata  = 16'hA5A5;
        step();
        tvalid = 1'b0;
        send_tile(16'h4433, 1'b0);
        send_tile(16'hEE55, 1'b0);
        send_tile(16'hFF66, 1'b0);
        wait_done();
        n_cmp++;
        if (log_addr.size() !== 6) begin
            n_err++;
            $display("FAIL write_valid_count: %0d required 6", log_addr.size());
        end
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            n_cmp++;
            if (log_addr[i] !== c_addr[i] || log_data[i] !== c_data[i]) begin
                n_err++;
                $display("FAIL write_valid[%0d]: (%0d,%0h) required (%0d,%0h)",
                         i, log_addr[i], log_data[i], c_addr[i], c_data[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        clear_log();
        start_xfer();
        send_tile(16'h2211, 1'b0);
        step();
        n_cmp++;
        if (wr_en !== 1'b1 || wr_addr !== 8'd2) begin
            n_err++;
            $display("FAIL second_write: wr_en=%0b addr=%0d required 1 2", wr_en, wr_addr);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({wr_en, wr_addr, wr_data, busy} !== '0) begin
            n_err++;
            $display("FAIL async_reset: wr_en=%0b addr=%0h data=%0h busy=%0b required all 0",
                     wr_en, wr_addr, wr_data, busy);
        end
        step();
        rst = 1'b0;
        step(); step();
        n_cmp++;
        if (log_addr.size() !== 1 || busy !== 1'b0 || wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL abandoned: writes=%0d busy=%0b wr_en=%0b required 1 0 0",
                     log_addr.size(), busy, wr_en);
        end
        clear_log();
        start_xfer();
        send_tile(16'h2211, 1'b0);
        send_tile(16'h4433, 1'b0);
        send_tile(16'hEE55, 1'b0);
        send_tile(16'hFF66, 1'b0);
        wait_done();
        n_cmp++;
        if (log_addr.size() !== 6 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL rerun_count: writes=%0d done=%0d required 6 1", log_addr.size(), done_cnt);
        end
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            n_cmp++;
            if (log_addr[i] !== c_addr[i] || log_data[i] !== c_data[i]) begin
                n_err++;
                $display("FAIL rerun_write[%0d]: (%0d,%0h) required (%0d,%0h)",
                         i, log_addr[i], log_data[i], c_addr[i], c_data[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        clear_log();
        start = 1'b1;
        step();
        send_tile(16'h2211, 1'b0);
        send_tile(16'h4433, 1'b0);
        send_tile(16'hEE55, 1'b0);
        send_tile(16'hFF66, 1'b0);
        start = 1'b0;
        wait_done();
        n_cmp++;
        if (log_addr.size() !== 6) begin
            n_err++;
            $display("FAIL start_ignored_count: %0d required 6", log_addr.size());
        end
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            n_cmp++;
            if (log_addr[i] !== c_addr[i] || log_data[i] !== c_data[i]) begin
                n_err++;
                $display("FAIL start_ignored_write[%0d]: (%0d,%0h) required (%0d,%0h)",
                         i, log_addr[i], log_data[i], c_addr[i], c_data[i]);
            end
        end
    endtask

    task automatic test_wide_tile;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        n_cmp++;
        if (tready4 !== 1'b1) begin
            n_err++;
            $display("FAIL wide_ready: %0b required 1", tready4);
        end
        tvalid4 = 1'b1;
        tdata4  = 32'h04030201;
        step();
        tvalid4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (wr_en4 !== 1'b1 || wr_addr4 !== 8'(i) || wr_data4 !== 8'(i + 1)) begin
                n_err++;
                $display("FAIL wide_write[%0d]: en=%0b (%0d,%0d) required 1 (%0d,%0d)",
                         i, wr_en4, wr_addr4, wr_data4, i, i + 1);
            end
            step();
        end
        n_cmp++;
        if (done4 !== 1'b1 || wr_en4 !== 1'b0) begin
            n_err++;
            $display("FAIL wide_done: done=%0b wr_en=%0b required 1 0", done4, wr_en4);
        end
        step();
        n_cmp++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL wide_idle: done=%0b busy=%0b required 0 0", done4, busy4);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_valid();
        test_async_reset();
        test_start_ignored();
        test_wide_tile();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
